// File: rtl/ac_motor_phase_gen.sv
// ---------------------------------------------------------------------------
// ac_motor_phase_gen
//
// Six-step three-phase square-wave generator. While running, it walks a
// 0..5 commutation step index; each step lasts L clock cycles, and the
// three phase outputs follow a fixed six-entry table. S1 leads S2 by
// 120 degrees, and S2 leads S3 by 120 degrees.
//
// Optional feature (compile-time macro AC_MOTOR_RAMP_EN):
//   Soft-start ramp. The first step lasts max(RAMP_START, STEP_DIV) cycles.
//   Each later step is RAMP_DEC cycles shorter, down to STEP_DIV. With the
//   macro undefined, L = STEP_DIV from the first step and no ramp logic
//   exists.
//
// Handshake / timing contract:
//   There is no valid/ready pair. i_en is a level request. i_step_div is
//   sampled only on RUN entry and at step boundaries. o_step_stb pulses for
//   one cycle whenever a new step pattern first appears on o_s1..o_s3.
//
// Ports:
//   i_clk        system clock (rising edge)
//   i_rst_n      asynchronous active-low reset
//   i_en         run request (1 = run, 0 = stop -> IDLE)
//   i_step_div   target step length in clock cycles (0 and 1 both mean 1)
//   o_s1..o_s3   registered phase outputs
//   o_step_idx   current commutation step 0..5
//   o_step_stb   one-cycle pulse on each new step
//   o_running    high while in RUN
//   o_dbg_state  raw FSM state register, for debug and checkers
// ---------------------------------------------------------------------------
module ac_motor_phase_gen #(
  parameter int DIV_WIDTH  = 16,
  parameter int RAMP_START = 1000,
  parameter int RAMP_DEC   = 10
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic [DIV_WIDTH-1:0] i_step_div,
  output logic                 o_s1,
  output logic                 o_s2,
  output logic                 o_s3,
  output logic [2:0]           o_step_idx,
  output logic                 o_step_stb,
  output logic                 o_running,
  output logic                 o_dbg_state
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [DIV_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [DIV_WIDTH-1:0] r_len, w_len_nxt;
  logic [2:0]           r_idx, w_idx_nxt;
  logic [2:0]           r_pat, w_pat_nxt;
  logic                 r_stb, w_stb_nxt;

  logic [DIV_WIDTH-1:0] w_div_eff;
  logic [DIV_WIDTH-1:0] w_len_first;
  logic [DIV_WIDTH-1:0] w_len_step;
  logic [2:0]           w_idx_adv;
  logic                 w_boundary;

  // {S1,S2,S3} for each commutation step.
  function automatic logic [2:0] step_pattern(input logic [2:0] idx);
    logic [2:0] pat;
    case (idx)
      3'd0:    pat = 3'b101;
      3'd1:    pat = 3'b100;
      3'd2:    pat = 3'b110;
      3'd3:    pat = 3'b010;
      3'd4:    pat = 3'b011;
      3'd5:    pat = 3'b001;
      default: pat = 3'b000;
    endcase
    return pat;
  endfunction

  // A step of 0 cycles is meaningless, so 0 is treated as 1.
  assign w_div_eff = (i_step_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(1) : i_step_div;

`ifdef AC_MOTOR_RAMP_EN
  localparam logic [DIV_WIDTH-1:0] RAMP_START_W = DIV_WIDTH'(RAMP_START);
  localparam logic [DIV_WIDTH-1:0] RAMP_DEC_W   = DIV_WIDTH'(RAMP_DEC);

  logic [DIV_WIDTH-1:0] w_len_dec;

  assign w_len_first = (RAMP_START_W > w_div_eff) ? RAMP_START_W : w_div_eff;
  // Saturate at zero before the max: a short L must never underflow to a
  // huge step length. A target above the current L wins at once through the
  // same max, so there is no deceleration ramp.
  assign w_len_dec   = (r_len > RAMP_DEC_W) ? (r_len - RAMP_DEC_W) : '0;
  assign w_len_step  = (w_len_dec > w_div_eff) ? w_len_dec : w_div_eff;
`else
  logic w_unused_ramp;

  assign w_len_first   = w_div_eff;
  assign w_len_step    = w_div_eff;
  // The ramp parameters have no effect in this build.
  assign w_unused_ramp = ^{RAMP_START, RAMP_DEC};
`endif

  // r_len is always >= 1 in RUN, so the counter stops at L-1 and never wraps.
  assign w_boundary = (r_cnt == (r_len - DIV_WIDTH'(1)));
  assign w_idx_adv  = (r_idx == 3'd5) ? 3'd0 : (r_idx + 3'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    w_pat_nxt   = r_pat;
    w_stb_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_en) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
          w_len_nxt   = w_len_first;
          w_idx_nxt   = 3'd0;
          w_pat_nxt   = step_pattern(3'd0);
          w_stb_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = '0;
          w_len_nxt = '0;
          w_idx_nxt = 3'd0;
          w_pat_nxt = 3'b000;
        end
      end
      ST_RUN: begin
        if (!i_en) begin
          // Stopping discards the step position. The next start begins at step 0.
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_len_nxt   = '0;
          w_idx_nxt   = 3'd0;
          w_pat_nxt   = 3'b000;
        end else if (w_boundary) begin
          w_cnt_nxt = '0;
          w_len_nxt = w_len_step;
          w_idx_nxt = w_idx_adv;
          w_pat_nxt = step_pattern(w_idx_adv);
          w_stb_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + DIV_WIDTH'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_len_nxt   = '0;
        w_idx_nxt   = 3'd0;
        w_pat_nxt   = 3'b000;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_idx   <= 3'd0;
      r_pat   <= 3'b000;
      r_stb   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_idx   <= w_idx_nxt;
      r_pat   <= w_pat_nxt;
      r_stb   <= w_stb_nxt;
    end
  end

  assign o_s1        = r_pat[2];
  assign o_s2        = r_pat[1];
  assign o_s3        = r_pat[0];
  assign o_step_idx  = r_idx;
  assign o_step_stb  = r_stb;
  assign o_running   = (r_state == ST_RUN);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ac_motor_phase_gen.sv
// ---------------------------------------------------------------------------
// tb_ac_motor_phase_gen
//
// Self-checking bench for ac_motor_phase_gen.
//
// The reference model tracks the step number, the remaining cycles in the
// step, and the step length. Phase levels come from the electrical angle:
// each phase is high for three consecutive steps, and the three phases are
// offset by two steps each.
//
// Inputs change on the falling edge. Outputs are compared on the falling
// edge that follows each rising edge.
// ---------------------------------------------------------------------------
module tb_ac_motor_phase_gen;
  localparam int DW = 16;
  localparam int RS = 10;
  localparam int RD = 3;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_en;
  logic [DW-1:0] i_step_div;
  logic          o_s1, o_s2, o_s3;
  logic [2:0]    o_step_idx;
  logic          o_step_stb;
  logic          o_running;
  logic          o_dbg_state;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  bit m_run;
  int m_idx;
  int m_len;
  int m_left;
  bit m_stb;

  ac_motor_phase_gen #(
    .DIV_WIDTH (DW),
    .RAMP_START(RS),
    .RAMP_DEC  (RD)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (i_en),
    .i_step_div (i_step_div),
    .o_s1       (o_s1),
    .o_s2       (o_s2),
    .o_s3       (o_s3),
    .o_step_idx (o_step_idx),
    .o_step_stb (o_step_stb),
    .o_running  (o_running),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got timeout, expected $finish before 2ms");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int clamp_div(input int d);
    return (d < 2) ? 1 : d;
  endfunction

  function automatic int first_len(input int d);
`ifdef AC_MOTOR_RAMP_EN
    return (RS > clamp_div(d)) ? RS : clamp_div(d);
`else
    return clamp_div(d);
`endif
  endfunction

  function automatic int next_len(input int len, input int d);
`ifdef AC_MOTOR_RAMP_EN
    return ((len - RD) > clamp_div(d)) ? (len - RD) : clamp_div(d);
`else
    return clamp_div(d) + 0 * len;
`endif
  endfunction

  function automatic void m_reset();
    m_run  = 1'b0;
    m_idx  = 0;
    m_len  = 0;
    m_left = 0;
    m_stb  = 1'b0;
  endfunction

  function automatic void model_edge(input bit en, input int div);
    if (!m_run) begin
      if (en) begin
        m_run  = 1'b1;
        m_idx  = 0;
        m_len  = first_len(div);
        m_left = m_len - 1;
        m_stb  = 1'b1;
      end else begin
        m_stb = 1'b0;
      end
    end else if (!en) begin
      m_reset();
    end else if (m_left == 0) begin
      m_idx  = (m_idx + 1) % 6;
      m_len  = next_len(m_len, div);
      m_left = m_len - 1;
      m_stb  = 1'b1;
    end else begin
      m_left = m_left - 1;
      m_stb  = 1'b0;
    end
  endfunction

  // A phase is high for three steps, starting at its own offset step.
  function automatic bit phase_high(input int idx, input int offset);
    return ((idx - offset + 6) % 6) < 3;
  endfunction

  function automatic logic [2:0] m_pattern();
    if (!m_run) return 3'b000;
    return {phase_high(m_idx, 0), phase_high(m_idx, 2), phase_high(m_idx, 4)};
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_pat"}, {29'd0, o_s1, o_s2, o_s3}, {29'd0, m_pattern()});
    check({tag, "_idx"}, {29'd0, o_step_idx}, m_idx);
    check({tag, "_stb"}, {31'd0, o_step_stb}, {31'd0, m_stb});
    check({tag, "_run"}, {31'd0, o_running}, {31'd0, m_run});
    check({tag, "_dbg"}, {31'd0, o_dbg_state}, {31'd0, m_run});
  endtask

  // ---------------- driver tasks ----------------
  // Called on a falling edge. Applies the inputs, advances the model on the
  // rising edge, and returns on the next falling edge.
  task automatic cyc(input bit en, input int div);
    i_en       = en;
    i_step_div = DW'(div);
    @(posedge i_clk);
    model_edge(en, div);
    @(negedge i_clk);
  endtask

  // Runs until the next step strobe. Returns the length of the current step.
  task automatic measure(input int div, output int len);
    len = 0;
    do begin
      cyc(1'b1, div);
      len++;
    end while (!o_step_stb && len < 100);
  endtask

  // Pulses reset between clock edges and checks the IDLE values before the
  // next rising edge.
  task automatic async_reset(input string tag);
    #2 i_rst_n = 1'b0;
    #1;
    check({tag, "_rst_pat"}, {29'd0, o_s1, o_s2, o_s3}, 32'd0);
    check({tag, "_rst_idx"}, {29'd0, o_step_idx}, 32'd0);
    check({tag, "_rst_stb"}, {31'd0, o_step_stb}, 32'd0);
    check({tag, "_rst_run"}, {31'd0, o_running}, 32'd0);
    m_reset();
    #1 i_rst_n = 1'b1;
  endtask

`ifndef AC_MOTOR_RAMP_EN
  typedef struct {
    bit         en;
    int         div;
    logic [2:0] s;
    logic [2:0] idx;
    bit         stb;
    bit         run;
  } vec_t;

  vec_t vecs[$];
  logic [2:0] pats[7] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

  function automatic void add_vec(input bit en, input int div, input logic [2:0] s,
                                  input int idx, input bit stb, input bit run);
    vec_t v;
    v.en  = en;
    v.div = div;
    v.s   = s;
    v.idx = 3'(idx);
    v.stb = stb;
    v.run = run;
    vecs.push_back(v);
  endfunction
`endif

  // ---------------- test sequence ----------------
  initial begin
    int  len;
    bit  found;

    i_rst_n    = 1'b1;
    i_en       = 1'b0;
    i_step_div = DW'(4);
    m_reset();
    #1 i_rst_n = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    check("reset_pat", {29'd0, o_s1, o_s2, o_s3}, 32'd0);
    check("reset_idx", {29'd0, o_step_idx}, 32'd0);
    check("reset_stb", {31'd0, o_step_stb}, 32'd0);
    check("reset_run", {31'd0, o_running}, 32'd0);
    i_rst_n = 1'b1;
    cyc(1'b0, 4);
    check_model("idle_hold");

`ifndef AC_MOTOR_RAMP_EN
    // Table: step length 4 for one full electrical period, then stop. Next,
    // STEP_DIV = 0 (new step every cycle), then stop again.
    for (int k = 0; k < 7; k++) begin
      add_vec(1'b1, 4, pats[k], k % 6, 1'b1, 1'b1);
      if (k < 6)
        for (int j = 0; j < 3; j++) add_vec(1'b1, 4, pats[k], k, 1'b0, 1'b1);
    end
    add_vec(1'b0, 4, 3'b000, 0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) add_vec(1'b1, 0, pats[k], k % 6, 1'b1, 1'b1);
    add_vec(1'b0, 0, 3'b000, 0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].en, vecs[i].div);
      check($sformatf("vec%0d_pat", i), {29'd0, o_s1, o_s2, o_s3}, {29'd0, vecs[i].s});
      check($sformatf("vec%0d_idx", i), {29'd0, o_step_idx}, {29'd0, vecs[i].idx});
      check($sformatf("vec%0d_stb", i), {31'd0, o_step_stb}, {31'd0, vecs[i].stb});
      check($sformatf("vec%0d_run", i), {31'd0, o_running}, {31'd0, vecs[i].run});
    end

    // STEP_DIV changes 4 -> 2 one cycle into step 1. Step 1 keeps length 4.
    cyc(1'b1, 4);
    for (int j = 0; j < 4; j++) cyc(1'b1, 4);
    check("div_chg_s1_idx", {29'd0, o_step_idx}, 32'd1);
    check("div_chg_s1_stb", {31'd0, o_step_stb}, 32'd1);
    for (int j = 0; j < 3; j++) begin
      cyc(1'b1, 2);
      check("div_chg_s1_hold", {29'd0, o_step_idx, o_step_stb}, {28'd0, 3'd1, 1'b0});
    end
    cyc(1'b1, 2);
    check("div_chg_s2_start", {29'd0, o_step_idx, o_step_stb}, {28'd0, 3'd2, 1'b1});
    cyc(1'b1, 2);
    check("div_chg_s2_hold", {29'd0, o_step_idx, o_step_stb}, {28'd0, 3'd2, 1'b0});
    cyc(1'b1, 2);
    check("div_chg_s3_start", {29'd0, o_step_idx, o_step_stb}, {28'd0, 3'd3, 1'b1});
    cyc(1'b1, 2);
    check("div_chg_s3_hold", {29'd0, o_step_idx, o_step_stb}, {28'd0, 3'd3, 1'b0});
    cyc(1'b1, 2);
    check("div_chg_s4_start", {29'd0, o_step_idx, o_step_stb}, {28'd0, 3'd4, 1'b1});
    cyc(1'b0, 2);
    check_model("div_chg_stop");
`else
    // Soft start: lengths 10, 7, 4, 4. A later target of 6 applies from the
    // next boundary.
    cyc(1'b1, 4);
    check("ramp_entry_stb", {31'd0, o_step_stb}, 32'd1);
    measure(4, len); check("ramp_len0", len, 32'd10);
    measure(4, len); check("ramp_len1", len, 32'd7);
    measure(4, len); check("ramp_len2", len, 32'd4);
    measure(4, len); check("ramp_len3", len, 32'd4);
    measure(6, len); check("ramp_len4", len, 32'd4);
    measure(6, len); check("ramp_len5", len, 32'd6);
    measure(6, len); check("ramp_len6", len, 32'd6);
    cyc(1'b0, 6);
    check_model("ramp_stop");
`endif

    // EN dropped during step 3 with counter = 1, then raised again.
    cyc(1'b1, 4);
    found = 1'b0;
    for (int j = 0; j < 200 && !found; j++) begin
      if (m_idx == 3 && m_left == m_len - 2) found = 1'b1;
      else cyc(1'b1, 4);
    end
    check("stop_reach_step3", {31'd0, found}, 32'd1);
    check("stop_pre_idx", {29'd0, o_step_idx}, 32'd3);
    cyc(1'b0, 4);
    check("stop_pat", {29'd0, o_s1, o_s2, o_s3}, 32'd0);
    check("stop_idx", {29'd0, o_step_idx}, 32'd0);
    check("stop_run", {31'd0, o_running}, 32'd0);
    cyc(1'b1, 4);
    check("restart_pat", {29'd0, o_s1, o_s2, o_s3}, 32'b101);
    check("restart_stb", {31'd0, o_step_stb}, 32'd1);

    // Asynchronous reset pulsed mid-run during step 4.
    found = 1'b0;
    for (int j = 0; j < 200 && !found; j++) begin
      if (m_idx == 4) found = 1'b1;
      else cyc(1'b1, 4);
    end
    check("rst_reach_step4", {31'd0, found}, 32'd1);
    async_reset("mid_step4");
    cyc(1'b1, 4);
    check("rst_restart_pat", {29'd0, o_s1, o_s2, o_s3}, 32'b101);
    check("rst_restart_idx", {29'd0, o_step_idx}, 32'd0);
    check("rst_restart_stb", {31'd0, o_step_stb}, 32'd1);
    check("rst_restart_run", {31'd0, o_running}, 32'd1);

    // Randomized run against the model.
    begin
      int rdiv;
      bit ren;
      rdiv = 3;
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(0, 199) == 0) begin
          async_reset("rand");
        end
        if ($urandom_range(0, 7) == 0)
          rdiv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 6));
        ren = ($urandom_range(0, 39) != 0);
        cyc(ren, rdiv);
        check_model("rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ac_motor_phase_gen.md
AC_MOTOR_PHASE_GEN -- requirements
Module: ac_motor_phase_gen

Interface
REQ-001 Parameter DIV_WIDTH, default 16: width of the step-period input and the internal cycle counter.
REQ-002 Parameter RAMP_START, default 1000: first step length in clock cycles when the ramp is compiled in.
REQ-003 Parameter RAMP_DEC, default 10: cycles removed from the step length at each step boundary during the ramp.
REQ-004 CLK  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 RST_N  input  1  asynchronous, active-low reset.
REQ-006 EN  input  1  run request; high runs the generator, low stops it.
REQ-007 STEP_DIV  input  DIV_WIDTH  target step length in CLK cycles (one step is 1/6 of an electrical period).
REQ-008 S1, S2, S3  output  1 each  three-phase square waves, registered; they feed the direction stage's S1_IN..S3_IN.
REQ-009 STEP_IDX  output  3  current commutation step, 0..5, registered.
REQ-010 STEP_STB  output  1  one-cycle pulse in the same cycle a new step pattern first appears.
REQ-011 RUNNING  output  1  high while the FSM is in RUN.

Function
REQ-012 FSM states SHALL be IDLE and RUN only.
REQ-013 In IDLE: S1..S3=000, STEP_IDX=0, STEP_STB=0, RUNNING=0, cycle counter=0.
REQ-014 IDLE->RUN on the first edge with EN=1; on that edge outputs SHALL take step 0, RUNNING=1, STEP_STB=1, counter=0.
REQ-015 Step table {S1,S2,S3}: 0=101, 1=100, 2=110, 3=010, 4=011, 5=001 (S1 leads S2 by 120 deg, S2 leads S3 by 120 deg).
REQ-016 In RUN, the counter increments every cycle; when counter==L-1 (L = current step length), the counter SHALL go to 0 and STEP_IDX SHALL advance on the same edge, wrapping 5->0, with STEP_STB=1 for that cycle.
REQ-017 Every step SHALL last exactly L cycles; the pattern and STEP_IDX change only at step boundaries.
REQ-018 STEP_DIV SHALL be sampled only on RUN entry and at each step boundary; a mid-step change takes effect from the next step.
REQ-019 STEP_DIV values 0 and 1 SHALL both give L=1 (a new step every cycle, 6-cycle electrical period).
REQ-020 RUN->IDLE on the first edge with EN=0, whatever the step or counter value; the IDLE values of REQ-013 SHALL apply from that edge.
REQ-021 If EN is low for one cycle and then high again, the next RUN entry SHALL restart at step 0 with a fresh length; no step position is retained.
REQ-022 The counter SHALL never exceed L-1 and SHALL NOT wrap through 2^DIV_WIDTH.

Reset
REQ-023 RST_N low SHALL force IDLE and all REQ-013 values immediately, without waiting for a clock edge.
REQ-024 Reset asserted mid-step SHALL discard the step state; after release, operation resumes only through REQ-014.
REQ-025 Release of RST_N SHALL be handled on the next CLK edge with no additional latency cycles.

Configuration
REQ-026 Macro AC_MOTOR_RAMP_EN SHALL select the soft-start ramp.
REQ-027 With AC_MOTOR_RAMP_EN defined:
- first step length = max(RAMP_START, STEP_DIV);
- at each boundary, new L = max(L-RAMP_DEC, STEP_DIV), computed without underflow;
- if the sampled STEP_DIV exceeds the current L, L SHALL jump to STEP_DIV at once (no decel ramp);
- the ramp restarts on every RUN entry.
REQ-028 Without AC_MOTOR_RAMP_EN: L = STEP_DIV (clamped per REQ-019) from the first step; the ramp parameters are ignored and no ramp logic is synthesised.

Verification
REQ-029 Ramp off, STEP_DIV=4, EN 0->1: pattern 101 and STB on the first edge, then 100, 110, 010, 011, 001, 101 every 4 cycles, one STB pulse per change, STEP_IDX 0..5..0.
REQ-030 Ramp off, STEP_DIV 4->2 one cycle into step 1: step 1 lasts 4 cycles; steps 2 onward last 2 cycles.
REQ-031 Ramp off, STEP_DIV=0: pattern changes every cycle, six-cycle period, STB high continuously.
REQ-032 EN dropped during step 3, counter=1: next edge gives 000, STEP_IDX=0, RUNNING=0; EN raised again restarts at 101.
REQ-033 RST_N pulsed low between clock edges during step 4: outputs 000 and RUNNING=0 before the next edge; after release with EN=1, restart at step 0.
REQ-034 AC_MOTOR_RAMP_EN, RAMP_START=10, RAMP_DEC=3, STEP_DIV=4: step lengths 10, 7, 4, 4, ...; then STEP_DIV set to 6 gives length 6 from the next boundary.
